// File: rtl/ieee_sd_arbiter_if.sv
// SD request bus between the per-device block request arrays and the single host SD port.
interface ieee_sd_arbiter_if #(
  parameter int NBD = 2,
  parameter int SW  = (NBD > 1) ? $clog2(NBD) : 1
);
  // Device side, one entry per block device
  logic [31:0]    dev_lba      [NBD];
  logic [5:0]     dev_blk_cnt  [NBD];
  logic [NBD-1:0] dev_rd;
  logic [NBD-1:0] dev_wr;
  logic [NBD-1:0] dev_ack;
  logic [7:0]     dev_buff_din [NBD];

  // Host side
  logic [31:0]    host_lba;
  logic [5:0]     host_blk_cnt;
  logic           host_rd;
  logic           host_wr;
  logic           host_ack;
  logic [7:0]     host_buff_din;
  logic [SW-1:0]  host_sel;
  logic           busy;

  // Arbiter view
  modport master (
    input  dev_lba, dev_blk_cnt, dev_rd, dev_wr, dev_buff_din, host_ack,
    output dev_ack, host_lba, host_blk_cnt, host_rd, host_wr, host_buff_din, host_sel, busy
  );

  // Environment view: devices plus host controller
  modport slave (
    output dev_lba, dev_blk_cnt, dev_rd, dev_wr, dev_buff_din, host_ack,
    input  dev_ack, host_lba, host_blk_cnt, host_rd, host_wr, host_buff_din, host_sel, busy
  );
endinterface

// File: rtl/ieee_sd_arbiter.sv
// Round-robin arbiter serialising per-device SD block requests onto one host SD port.
module ieee_sd_arbiter #(
  parameter int NBD = 2,
  parameter int SW  = (NBD > 1) ? $clog2(NBD) : 1
) (
  input logic               clk_sys,
  input logic               reset_n,
  ieee_sd_arbiter_if.master sd
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Device 0 gets first priority out of reset
  localparam logic [SW-1:0] LastRst = SW'(NBD - 1);

  logic [1:0]     rst_sync;
  logic           rst_int_n;
  logic [1:0]     state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [SW-1:0]  last_q, last_d;
  logic [31:0]    lba_q, lba_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [NBD-1:0] pending;
  logic [NBD-1:0] ack_c;
  logic [SW-1:0]  grant_idx;
  logic           grant_ok;

  // Reset synchroniser: asserts immediately, releases two edges after reset_n rises
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync[1];
  assign pending   = sd.dev_rd | sd.dev_wr;

  // Round-robin scan: first pending device after the last one served
  always_comb begin
    int idx;
    idx       = 0;
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NBD; k++) begin
      idx = (int'(last_q) + k) % NBD;
      if (!grant_ok && pending[SW'(idx)]) begin
        grant_ok  = 1'b1;
        grant_idx = SW'(idx);
      end
    end
  end

  // Next-state logic for the transfer FSM and latched grant
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    lba_d   = lba_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        // A stray acknowledge blocks any new grant
        if (grant_ok && !sd.host_ack) begin
          sel_d   = grant_idx;
          lba_d   = sd.dev_lba[grant_idx];
          cnt_d   = sd.dev_blk_cnt[grant_idx];
          // Read wins a collision; the write remains pending
          rd_d    = sd.dev_rd[grant_idx];
          wr_d    = !sd.dev_rd[grant_idx];
          state_d = REQ;
        end
      end
      REQ: begin
        if (sd.host_ack) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (!sd.host_ack) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer state registers
  always_ff @(posedge clk_sys or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= LastRst;
      lba_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Route the host acknowledge to the granted device only
  always_comb begin
    ack_c = '0;
    if (sd.host_ack && (state_q == REQ || state_q == XFER)) begin
      ack_c[sel_q] = 1'b1;
    end
  end

  assign sd.dev_ack       = ack_c;
  assign sd.host_lba      = lba_q;
  assign sd.host_blk_cnt  = cnt_q;
  assign sd.host_rd       = rd_q;
  assign sd.host_wr       = wr_q;
  assign sd.host_sel      = sel_q;
  assign sd.host_buff_din = sd.dev_buff_din[sel_q];
  assign sd.busy          = (state_q != IDLE);

endmodule

// File: doc/ieee_sd_arbiter.md
# ieee_sd_arbiter

Serialises the per-subunit SD block requests of the IEEE drive complex onto one host SD port. It sits directly downstream of the drive complex's `sd_lba/sd_blk_cnt/sd_rd/sd_wr/sd_ack/sd_buff_din` arrays, one entry per block device, and faces a single-slot SD host controller. Devices are granted round-robin, and the host's acknowledge and data are routed back to the granted device only.

## Interface
Parameters:
- NBD, 2: number of block devices (drives × subunits), 1..8.
- SW, $clog2(NBD) (min 1): width of the select index.

Ports:
- clk_sys  in  1  system clock; all logic is in this domain.
- reset_n  in  1  asynchronous, active-low reset.
- dev_lba[NBD]  in  32  per-device LBA request.
- dev_blk_cnt[NBD]  in  6  per-device block count minus one.
- dev_rd  in  NBD  per-device read request; a level held until acknowledged.
- dev_wr  in  NBD  per-device write request; a level held until acknowledged.
- dev_ack  out  NBD  per-device acknowledge.
- dev_buff_din[NBD]  in  8  per-device write data.
- host_lba  out  32  granted LBA.
- host_blk_cnt  out  6  granted block count.
- host_rd  out  1  host read request.
- host_wr  out  1  host write request.
- host_ack  in  1  host acknowledge; high for the whole transfer.
- host_buff_din  out  8  write data to the host, taken from the granted device.
- host_sel  out  SW  index of the granted device.
- busy  out  1  high from grant until return to IDLE.

## Operation
- The FSM has four states: IDLE, REQ, XFER, DONE.
- IDLE:
  - Pending vector = dev_rd | dev_wr.
  - Scan round-robin starting at last+1 (mod NBD) and take the first pending device g.
  - Grant only when host_ack is low.
  - On grant:
    - latch host_sel=g, host_lba=dev_lba[g], host_blk_cnt=dev_blk_cnt[g];
    - set dir=rd if dev_rd[g], else wr; read wins when both are set, and the write stays pending for a later grant;
    - assert host_rd or host_wr;
    - go to REQ.
- REQ:
  - Hold host_rd/host_wr until host_ack is sampled high, then clear both and go to XFER.
  - If the device drops its request while in REQ, the transfer still completes; the request is not withdrawn.
- XFER: stay while host_ack is high; when host_ack is sampled low go to DONE.
- DONE: set last=host_sel and go to IDLE.
- dev_ack[i] = host_ack & (state is REQ or XFER) & (host_sel==i). It is combinational; all other dev_ack bits are 0.
- host_buff_din = dev_buff_din[host_sel], combinational.
- sd_buff_addr, sd_buff_dout and sd_buff_wr are broadcast by the parent and are not routed through this block.
- Fairness: a device that re-requests immediately after DONE is served only after every other pending device has had one grant.

## Timing
- Reset (async assert, sync-released inside the block):
  - host_rd=host_wr=0, host_lba=0, host_blk_cnt=0, host_sel=0, busy=0, state=IDLE;
  - last=NBD-1, so device 0 has first priority;
  - dev_ack=0 and host_buff_din=dev_buff_din[0] (purely from host_sel=0).
- Grant latency: a request sampled at edge N in IDLE (with host_ack low) gives host_rd/host_wr, host_lba, host_sel and busy valid after edge N.
- host_rd/host_wr deassert on the edge after host_ack is first sampled high.
- host_ack low sampled at edge M gives DONE after M and IDLE after M+1. The earliest next grant is therefore at edge M+2, giving a minimum gap of 2 idle cycles between transfers.
- Reset mid-transfer: all outputs go to their reset values immediately. If host_ack is still high after reset, no grant is issued until it falls.
- NBD=1: the scan degenerates to device 0, host_sel is constant 0, and behaviour is otherwise identical.
- host_ack high while in IDLE (stray acknowledge): ignored. No dev_ack is produced and no grant is issued until host_ack is low.

## Test plan
- Single read:
  - Stimulus: dev_rd[1]=1 with dev_lba[1]=0x1234, blk_cnt=3; host raises ack 5 cycles later, holds it 10 cycles, then drops it.
  - Required: host_rd=1, host_lba=0x1234, host_sel=1 one edge after the request; dev_ack[1] mirrors ack; busy falls 2 edges after ack falls.
- Round-robin:
  - Stimulus: dev_rd=2'b11 held, re-asserted after each ack.
  - Required: grant order 0,1,0,1; host_sel never repeats while the other device is pending.
- Read/write collision:
  - Stimulus: dev_rd[0]=dev_wr[0]=1.
  - Required: first grant host_rd=1, host_wr=0; the second grant is host_wr with the same device.
- Write data mux:
  - Stimulus: device 1 granted for write; dev_buff_din[0]=0xAA, dev_buff_din[1]=0x55.
  - Required: host_buff_din=0x55 throughout XFER.
- Reset mid-XFER:
  - Stimulus: reset_n pulsed low during XFER with host_ack high.
  - Required: outputs zero immediately; no new grant until host_ack falls; then device 0 is served first.
- Stray acknowledge:
  - Stimulus: host_ack=1 in IDLE with dev_wr[1]=1.
  - Required: dev_ack=0 and no grant; grant on the first edge after host_ack is low.
